// File: rtl/prbs_pkg.sv
// Shared types, constants and the PRBS-7 prediction helper for the checker.
package prbs_pkg;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } chk_state_t;

  localparam int unsigned PRBS7_W     = 7;
  localparam int unsigned PRBS7_TAP_A = 6;
  localparam int unsigned PRBS7_TAP_B = 5;

  // Next bit of x^7 + x^6 + 1 given the last seven bits (bit 0 newest).
  function automatic logic prbs7_next(input logic [PRBS7_W-1:0] s);
    return s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B];
  endfunction

endpackage

// File: rtl/prbs7_checker_if.sv
// Stream and status bundle between a bit-stream source and the PRBS-7 checker.
interface prbs7_checker_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic             valid_i;
  logic             bit_i;
  logic             clear_i;
  logic             locked_o;
  logic             err_o;
  logic [CNT_W-1:0] err_cnt_o;

  modport master (
    output valid_i, bit_i, clear_i,
    input  locked_o, err_o, err_cnt_o
  );

  modport slave (
    input  valid_i, bit_i, clear_i,
    output locked_o, err_o, err_cnt_o
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that still admits a same-cycle increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over the stored value; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS-7 checker: hunts, verifies, locks, then counts bit errors.
module prbs7_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_CNT    = 16,
  parameter int unsigned UNLOCK_ERRS = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic            clk,
  input  logic            reset,
  prbs7_checker_if.slave  bus
);

  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned RUN_W   = $clog2(UNLOCK_ERRS + 1);

  chk_state_t         state_q, state_d;
  logic [PRBS7_W-1:0] s_q, s_d;
  logic [2:0]         fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               err_q, err_d;
  logic               pred, miss, count_inc;

  assign pred = prbs7_next(s_q);
  assign miss = (bus.bit_i != pred);

  // Next-state: only valid beats advance; err pulse defaults low every cycle.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    fill_d    = fill_q;
    match_d   = match_q;
    run_d     = run_q;
    err_d     = 1'b0;
    count_inc = 1'b0;
    if (bus.valid_i) begin
      unique case (state_q)
        HUNT: begin
          s_d    = {s_q[PRBS7_W-2:0], bus.bit_i};
          fill_d = fill_q + 3'd1;
          if (fill_d == 3'(PRBS7_W)) begin
            state_d = VERIFY;
            match_d = '0;
          end
        end
        VERIFY: begin
          s_d = {s_q[PRBS7_W-2:0], bus.bit_i};
          // All-zero register is the LFSR lock-up state, never a real sequence.
          if (miss || (s_q == '0)) begin
            state_d = HUNT;
            fill_d  = '0;
          end else begin
            match_d = match_q + MATCH_W'(1);
            if (match_d == MATCH_W'(LOCK_CNT)) begin
              state_d = LOCKED;
              run_d   = '0;
            end
          end
        end
        LOCKED: begin
          // Free-run on the prediction so line errors cannot corrupt the reference.
          s_d = {s_q[PRBS7_W-2:0], pred};
          if (miss) begin
            err_d     = 1'b1;
            count_inc = 1'b1;
            run_d     = run_q + RUN_W'(1);
            if (run_d == RUN_W'(UNLOCK_ERRS)) begin
              state_d = HUNT;
              s_d     = '0;
              fill_d  = '0;
              run_d   = '0;
            end
          end else begin
            run_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= HUNT;
      s_q     <= '0;
      fill_q  <= '0;
      match_q <= '0;
      run_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clear_i),
    .inc   (count_inc),
    .cnt   (bus.err_cnt_o)
  );

  assign bus.locked_o = (state_q == LOCKED);
  assign bus.err_o    = err_q;

endmodule

// File: doc/prbs7_checker.md
Name: prbs7_checker

Overview:
- Receive-side partner to a serial bit-stream driver: consumes a 1-bit data stream qualified by a valid strobe.
- Self-synchronises to a PRBS-7 sequence (x^7 + x^6 + 1), declares lock, then counts bit errors.
- Sits at the far end of a flop or pipe chain to prove data integrity through the chain in simulation and on silicon.

Parameters:
- LOCK_CNT, 16: consecutive correct predicted bits required in VERIFY before lock is declared (>=1).
- UNLOCK_ERRS, 4: consecutive mismatching bits in LOCKED that drop lock (>=1).
- CNT_W, 16: width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- valid_i  input  1  bit_i is meaningful this cycle.
- bit_i  input  1  received serial data bit.
- clear_i  input  1  synchronous clear of err_cnt_o.
- locked_o  output  1  checker is locked to the sequence.
- err_o  output  1  one-cycle pulse flagging a mismatched bit while locked.
- err_cnt_o  output  CNT_W  saturating count of errors since reset or clear.

Behaviour:
- Reset (reset==0 at a clk edge): state=HUNT, shift reg s[6:0]=0, fill/match/err run counters=0, locked_o=0, err_o=0, err_cnt_o=0. Reset overrides all other inputs, including mid-lock.
- Only beats with valid_i==1 advance anything. With valid_i==0, all state holds, and err_o=0 on the next cycle.
- Prediction: p = s[6]^s[5]; mismatch m = (bit_i != p).
- HUNT:
  - s <= {s[5:0], bit_i}; fill count increments.
  - After the 7th valid bit, go to VERIFY with match count=0.
- VERIFY:
  - s <= {s[5:0], bit_i} (self-synchronising).
  - If m==1 or s==0 (the all-zero lock-up state is illegal): go to HUNT and reset the fill count.
  - Otherwise, increment the match count. When it reaches LOCK_CNT, go to LOCKED.
  - locked_o rises on the edge that performs the transition.
- LOCKED:
  - s <= {s[5:0], p} (free-running, so received errors do not corrupt the reference).
  - m==1: err_o=1 on the next cycle (registered, latency 1); err_cnt_o increments; consecutive-error run increments.
  - m==0: the run counter clears.
  - When the run reaches UNLOCK_ERRS: go to HUNT, locked_o=0, s cleared, fill count=0. The final error of the run is still pulsed and counted.
- Errors are never counted in HUNT or VERIFY. err_o stays 0 there.
- Counter rules:
  - err_cnt_o saturates at 2^CNT_W-1 and never wraps.
  - clear_i has priority over the stored value: clear_i with a counted error in the same cycle gives err_cnt_o=1; clear_i alone gives 0.
  - clear_i does not affect lock state.
- Minimum time to lock on a clean stream: 7 + LOCK_CNT valid bits.

Decomposition:
- Package prbs_pkg:
  - state enum chk_state_t {HUNT, VERIFY, LOCKED}.
  - Constants PRBS7_W=7, PRBS7_TAP_A=6, PRBS7_TAP_B=5.
  - Function prbs7_next(s), returning the predicted bit.
- Sub-module sat_counter (parameter W; ports clk, reset, clr, inc, cnt) implements err_cnt_o, so the clear/increment/saturate rules are tested once and reused.

Test Plan:
- Clean PRBS-7 stream seeded 7'h7F, valid_i=1 every cycle, defaults -> locked_o rises after exactly 23 valid bits; err_cnt_o stays 0 over 500 bits.
- After lock, invert a single bit -> err_o high for exactly one cycle, one cycle after that bit; err_cnt_o=1; locked_o stays 1; no follow-on errors.
- After lock, invert 4 consecutive bits -> four err_o pulses; err_cnt_o=4; locked_o falls on the 4th. Clean stream thereafter -> relock after 23 further bits.
- All-zero stream of 100 bits -> locked_o never asserts; err_cnt_o=0.
- Clean stream with valid_i toggling 1/0 every cycle -> lock after 23 valid beats (~46 cycles); an inverted bit is counted only on a valid beat.
- Saturation and reset:
  - CNT_W=2, locked, inject 5 isolated errors -> err_cnt_o=3 (saturated).
  - clear_i coincident with the next error -> err_cnt_o=1.
  - reset=0 for one cycle mid-lock -> all outputs 0 next cycle; state=HUNT.
